// File: rtl/prog_run_pkg.sv
// rtl/prog_run_pkg.sv - shared types and defaults for the program run sequencer
package prog_run_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CRST   = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4,
    ABORT  = 3'd5
  } run_state_t;

  localparam int          CW_DEFAULT      = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 32'h0000_FFFF;

endpackage

// File: rtl/prog_run_ctrl_run_timer.sv
// rtl/prog_run_ctrl_run_timer.sv - saturating cycle counter with terminal-count compare
// Supplies the per-program cycle count and the watchdog hit (count+1 == limit).
module run_timer #(
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW:0]   count_p1;

  // Extra bit catches wrap so the increment can saturate at all-ones.
  assign count_p1     = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};
  assign count_next_o = count_p1[CW] ? count_q : count_p1[CW-1:0];
  assign tc_o         = (count_p1 == {1'b0, limit_i});
  assign count_o      = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_next_o;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prog_run_ctrl.sv
// rtl/prog_run_ctrl.sv - batch run sequencer driving the core Start/Ack handshake
// Optional core reset, one Start per program, per-program cycle timing and a watchdog.
module prog_run_ctrl
  import prog_run_pkg::*;
#(
  parameter  int          NPROG   = 4,
  parameter  int          CW      = CW_DEFAULT,
  parameter  logic [CW-1:0] TIMEOUT = CW'(TIMEOUT_DEFAULT),
  localparam int          IW      = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          HostGo,
  input  logic          HostAbort,
  input  logic [IW-1:0] ProgLast,
  input  logic          CoreAck,
  output logic          CoreStart,
  output logic          CoreReset,
  output logic [IW-1:0] ProgIdx,
  output logic [CW-1:0] CycleCount,
  output logic [CW-1:0] LastCycles,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout
);

  run_state_t    state_q, state_d;
  logic [IW-1:0] prog_idx_q, prog_idx_d;
  logic [IW-1:0] prog_last_q, prog_last_d;
  logic [CW-1:0] last_cycles_q, last_cycles_d;
  logic          timeout_q, timeout_d;

  logic [CW-1:0] cycle_count;
  logic [CW-1:0] cycle_count_next;
  logic          wd_hit;

  run_timer #(
    .CW(CW)
  ) u_run_timer (
    .Clk          (Clk),
    .Reset        (Reset),
    .clr_i        (state_q == START),
    .en_i         (state_q == RUN),
    .limit_i      (TIMEOUT),
    .count_o      (cycle_count),
    .count_next_o (cycle_count_next),
    .tc_o         (wd_hit)
  );

  always_comb begin
    state_d       = state_q;
    prog_idx_d    = prog_idx_q;
    prog_last_d   = prog_last_q;
    last_cycles_d = last_cycles_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (HostGo) begin
          prog_last_d = ProgLast;
          prog_idx_d  = '0;
          timeout_d   = 1'b0;
          state_d     = CRST;
        end
      end
      CRST:  state_d = HostAbort ? ABORT : START;
      START: state_d = HostAbort ? ABORT : RUN;
      RUN: begin
        // Abort beats Ack beats watchdog; the Ack cycle itself is counted.
        if (HostAbort) begin
          state_d = ABORT;
        end else if (CoreAck) begin
          last_cycles_d = cycle_count_next;
          if (prog_idx_q == prog_last_q) begin
            state_d = FINISH;
          end else begin
            prog_idx_d = prog_idx_q + 1'b1;
            state_d    = START;
          end
        end else if (wd_hit) begin
          timeout_d = 1'b1;
          state_d   = ABORT;
        end
      end
      FINISH:  state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      prog_idx_q    <= '0;
      prog_last_q   <= '0;
      last_cycles_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_idx_q    <= prog_idx_d;
      prog_last_q   <= prog_last_d;
      last_cycles_q <= last_cycles_d;
      timeout_q     <= timeout_d;
    end
  end

  // Pulses decode from registered state only so they never glitch on inputs.
  assign CoreStart  = (state_q == START);
  assign CoreReset  = (state_q == CRST) || (state_q == ABORT);
  assign Done       = (state_q == FINISH);
  assign Busy       = (state_q != IDLE);
  assign ProgIdx    = prog_idx_q;
  assign CycleCount = cycle_count;
  assign LastCycles = last_cycles_q;
  assign Timeout    = timeout_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb/tb_prog_run_ctrl.sv - table-driven bench for prog_run_ctrl
module tb_prog_run_ctrl;

  logic        Clk;
  logic        Reset;
  logic        HostGo;
  logic        HostAbort;
  logic [1:0]  ProgLast;
  logic        CoreAck;
  logic        CoreStart;
  logic        CoreReset;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;
  logic [15:0] LastCycles;
  logic        Busy;
  logic        Done;
  logic        Timeout;

  int n_cmp = 0;
  int n_err = 0;

  int cnt_start = 0;
  int cnt_reset = 0;
  int cnt_done  = 0;

  prog_run_ctrl #(
    .NPROG   (4),
    .CW      (16),
    .TIMEOUT (16'd8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .HostGo     (HostGo),
    .HostAbort  (HostAbort),
    .ProgLast   (ProgLast),
    .CoreAck    (CoreAck),
    .CoreStart  (CoreStart),
    .CoreReset  (CoreReset),
    .ProgIdx    (ProgIdx),
    .CycleCount (CycleCount),
    .LastCycles (LastCycles),
    .Busy       (Busy),
    .Done       (Done),
    .Timeout    (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (CoreStart) cnt_start++;
    if (CoreReset) cnt_reset++;
    if (Done)      cnt_done++;
  end

  typedef struct {
    logic        rst, go, ab, ack;
    logic [1:0]  last;
    logic        cs, cr;
    logic [1:0]  idx;
    logic [15:0] cyc, lcy;
    logic        busy, done, tmo;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic rst, go, ab, ack, input logic [1:0] last,
                             input logic cs, cr, input logic [1:0] idx,
                             input logic [15:0] cyc, lcy, input logic busy, done, tmo);
    vec_t r;
    r.rst = rst; r.go = go; r.ab = ab; r.ack = ack; r.last = last;
    r.cs = cs; r.cr = cr; r.idx = idx; r.cyc = cyc; r.lcy = lcy;
    r.busy = busy; r.done = done; r.tmo = tmo;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [38:0] act_v, exp_v;
    int          i;
    int          s0, r0, d0;
    int          runs[3];

    Reset = 1'b1; HostGo = 1'b0; HostAbort = 1'b0; ProgLast = 2'd0; CoreAck = 1'b0;
    repeat (3) @(negedge Clk);

    // single program, Ack on 5th RUN cycle
    vt.push_back(v(0,1,0,0,0, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,0,0,0,0, 0,1,0,0,0,1,0,0));
    vt.push_back(v(0,0,0,0,0, 1,0,0,0,0,1,0,0));
    for (int k = 0; k < 4; k++) vt.push_back(v(0,0,0,0,0, 0,0,0,16'(k),0,1,0,0));
    vt.push_back(v(0,0,0,1,0, 0,0,0,4,0,1,0,0));
    vt.push_back(v(0,0,0,0,0, 0,0,0,5,5,1,1,0));
    vt.push_back(v(0,0,0,0,0, 0,0,0,5,5,0,0,0));
    // Ack held through START, HostGo while busy ignored
    vt.push_back(v(0,1,0,0,0, 0,0,0,5,5,0,0,0));
    vt.push_back(v(0,1,0,0,3, 0,1,0,5,5,1,0,0));
    vt.push_back(v(0,1,0,1,3, 1,0,0,5,5,1,0,0));
    vt.push_back(v(0,0,0,1,3, 0,0,0,0,5,1,0,0));
    vt.push_back(v(0,0,0,0,0, 0,0,0,1,1,1,1,0));
    vt.push_back(v(0,0,0,0,0, 0,0,0,1,1,0,0,0));
    // watchdog after 8 RUN cycles, then HostGo clears Timeout, abort in CRST
    vt.push_back(v(0,1,0,0,0, 0,0,0,1,1,0,0,0));
    vt.push_back(v(0,0,0,0,0, 0,1,0,1,1,1,0,0));
    vt.push_back(v(0,0,0,0,0, 1,0,0,1,1,1,0,0));
    for (int k = 0; k < 8; k++) vt.push_back(v(0,0,0,0,0, 0,0,0,16'(k),1,1,0,0));
    vt.push_back(v(0,0,0,0,0, 0,1,0,8,1,1,0,1));
    vt.push_back(v(0,0,0,0,0, 0,0,0,8,1,0,0,1));
    vt.push_back(v(0,1,0,0,0, 0,0,0,8,1,0,0,1));
    vt.push_back(v(0,0,1,0,0, 0,1,0,8,1,1,0,0));
    vt.push_back(v(0,0,0,0,0, 0,1,0,8,1,1,0,0));
    vt.push_back(v(0,0,0,0,0, 0,0,0,8,1,0,0,0));
    // HostAbort and CoreAck together in RUN
    vt.push_back(v(0,1,0,0,1, 0,0,0,8,1,0,0,0));
    vt.push_back(v(0,0,0,0,1, 0,1,0,8,1,1,0,0));
    vt.push_back(v(0,0,0,0,1, 1,0,0,8,1,1,0,0));
    vt.push_back(v(0,0,0,0,1, 0,0,0,0,1,1,0,0));
    vt.push_back(v(0,0,1,1,1, 0,0,0,1,1,1,0,0));
    vt.push_back(v(0,0,0,0,1, 0,1,0,2,1,1,0,0));
    vt.push_back(v(0,0,0,0,1, 0,0,0,2,1,0,0,0));
    // Reset mid-RUN with ProgIdx=1, CycleCount=4
    vt.push_back(v(0,1,0,0,1, 0,0,0,2,1,0,0,0));
    vt.push_back(v(0,0,0,0,1, 0,1,0,2,1,1,0,0));
    vt.push_back(v(0,0,0,0,1, 1,0,0,2,1,1,0,0));
    vt.push_back(v(0,0,0,1,1, 0,0,0,0,1,1,0,0));
    vt.push_back(v(0,0,0,0,1, 1,0,1,1,1,1,0,0));
    for (int k = 0; k < 4; k++) vt.push_back(v(0,0,0,0,1, 0,0,1,16'(k),1,1,0,0));
    vt.push_back(v(1,0,0,0,1, 0,0,1,4,1,1,0,0));
    vt.push_back(v(0,0,0,0,1, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,0,0,0,1, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,0,0,1,1, 0,0,0,0,0,0,0,0));
    vt.push_back(v(0,0,0,0,1, 0,0,0,0,0,0,0,0));

    for (int r = 0; r < vt.size(); r++) begin
      @(negedge Clk);
      Reset = vt[r].rst; HostGo = vt[r].go; HostAbort = vt[r].ab;
      CoreAck = vt[r].ack; ProgLast = vt[r].last;
      #1;
      exp_v = {vt[r].cs, vt[r].cr, vt[r].idx, vt[r].cyc, vt[r].lcy,
               vt[r].busy, vt[r].done, vt[r].tmo};
      act_v = {CoreStart, CoreReset, ProgIdx, CycleCount, LastCycles, Busy, Done, Timeout};
      check($sformatf("row%0d {cs,cr,idx,cyc,lcy,busy,done,tmo}", r), act_v, exp_v);
    end

    // three-program batch, Acks after 3, 7 and 1 RUN cycles
    Reset = 1'b0; HostAbort = 1'b0; CoreAck = 1'b0;
    runs[0] = 3; runs[1] = 7; runs[2] = 1;
    s0 = cnt_start; r0 = cnt_reset; d0 = cnt_done;
    @(negedge Clk);
    HostGo = 1'b1; ProgLast = 2'd2;
    @(negedge Clk);
    HostGo = 1'b0; ProgLast = 2'd0;
    for (int p = 0; p < 3; p++) begin
      i = 0;
      while (!CoreStart && i < 20) begin
        @(negedge Clk);
        i++;
      end
      check($sformatf("batch start%0d seen", p), CoreStart, 1);
      check($sformatf("batch idx%0d", p), ProgIdx, p);
      for (int k = 1; k <= runs[p]; k++) begin
        @(negedge Clk);
        CoreAck = (k == runs[p]);
      end
      @(negedge Clk);
      CoreAck = 1'b0;
      check($sformatf("batch lastcycles%0d", p), LastCycles, runs[p]);
    end
    check("batch done pulse", Done, 1);
    check("batch final idx", ProgIdx, 2);
    repeat (2) @(negedge Clk);
    #1;
    check("batch busy after done", Busy, 0);
    check("batch start pulses", cnt_start - s0, 3);
    check("batch reset pulses", cnt_reset - r0, 1);
    check("batch done pulses", cnt_done - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
